// File: rtl/chacha_driver_if.sv
// Handshake and core-facing bus of the ChaCha session driver.
// The master modport is the driver's view; slave is the environment/core view.
interface chacha_driver_if;
  logic       start;
  logic [7:0] num_blocks;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic       chacha_wr_key;
  logic       chacha_wr_nnc;
  logic       chacha_wr_ctr;
  logic [7:0] chacha_data_in;
  logic       chacha_blk_ready;
  logic       chacha_rd_blk;
  logic [7:0] chacha_data_out;

  modport master (
    input  start, num_blocks, cfg_valid, cfg_data, out_ready,
           chacha_blk_ready, chacha_data_out,
    output cfg_ready, out_valid, out_data, out_last, busy, done,
           chacha_wr_key, chacha_wr_nnc, chacha_wr_ctr, chacha_data_in,
           chacha_rd_blk
  );

  modport slave (
    output start, num_blocks, cfg_valid, cfg_data, out_ready,
           chacha_blk_ready, chacha_data_out,
    input  cfg_ready, out_valid, out_data, out_last, busy, done,
           chacha_wr_key, chacha_wr_nnc, chacha_wr_ctr, chacha_data_in,
           chacha_rd_blk
  );
endinterface

// File: rtl/chacha_driver.sv
// Session driver for a byte-serial ChaCha core: loads key/nonce/counter,
// streams keystream blocks with backpressure, and rewrites the counter per block.
module chacha_driver #(
  parameter int KEY_BYTES = 32,
  parameter int NNC_BYTES = 12,
  parameter int CTR_BYTES = 4,
  parameter int BLK_BYTES = 64
) (
  input logic            clk,
  input logic            rst,
  chacha_driver_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD_KEY, LOAD_NNC, LOAD_CTR, WAIT_BLK, READ, NEXT_CTR, DONE
  } state_t;

  localparam logic [7:0] KEY_LAST = 8'(KEY_BYTES - 1);
  localparam logic [7:0] NNC_LAST = 8'(NNC_BYTES - 1);
  localparam logic [7:0] CTR_LAST = 8'(CTR_BYTES - 1);
  localparam logic [7:0] BLK_LAST = 8'(BLK_BYTES - 1);

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  blk_q, blk_d;
  logic [7:0]  nblk_q, nblk_d;
  logic [31:0] ctr_q, ctr_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [4:0]  sh;
  logic [31:0] ctr_shift;
  logic        last_blk;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    blk_d       = blk_q;
    nblk_d      = nblk_q;
    ctr_d       = ctr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    sh          = {byte_q[1:0], 3'b000};
    ctr_shift   = ctr_q >> sh;
    last_blk    = (blk_q + 8'd1) == nblk_q;

    bus.cfg_ready      = 1'b0;
    bus.chacha_wr_key  = 1'b0;
    bus.chacha_wr_nnc  = 1'b0;
    bus.chacha_wr_ctr  = 1'b0;
    bus.chacha_data_in = 8'd0;
    bus.chacha_rd_blk  = 1'b0;
    bus.done           = 1'b0;

    // A held byte leaves the output register once accepted; READ may refill it.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.num_blocks != 8'd0)) begin
          state_d = LOAD_KEY;
          nblk_d  = bus.num_blocks;
          byte_d  = 8'd0;
          blk_d   = 8'd0;
        end
      end
      LOAD_KEY: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          bus.chacha_wr_key  = 1'b1;
          bus.chacha_data_in = bus.cfg_data;
          byte_d             = byte_q + 8'd1;
          if (byte_q == KEY_LAST) begin
            byte_d  = 8'd0;
            state_d = LOAD_NNC;
          end
        end
      end
      LOAD_NNC: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          bus.chacha_wr_nnc  = 1'b1;
          bus.chacha_data_in = bus.cfg_data;
          byte_d             = byte_q + 8'd1;
          if (byte_q == NNC_LAST) begin
            byte_d  = 8'd0;
            state_d = LOAD_CTR;
          end
        end
      end
      LOAD_CTR: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid) begin
          bus.chacha_wr_ctr  = 1'b1;
          bus.chacha_data_in = bus.cfg_data;
          ctr_d  = (ctr_q & ~(32'hFF << sh)) | ({24'd0, bus.cfg_data} << sh);
          byte_d = byte_q + 8'd1;
          if (byte_q == CTR_LAST) begin
            byte_d  = 8'd0;
            state_d = WAIT_BLK;
          end
        end
      end
      WAIT_BLK: begin
        if (bus.chacha_blk_ready) state_d = READ;
      end
      READ: begin
        bus.chacha_rd_blk = !out_valid_q || bus.out_ready;
        if (bus.chacha_rd_blk) begin
          out_valid_d = 1'b1;
          out_data_d  = bus.chacha_data_out;
          out_last_d  = (byte_q == BLK_LAST) && last_blk;
          byte_d      = byte_q + 8'd1;
          if (byte_q == BLK_LAST) begin
            byte_d = 8'd0;
            blk_d  = blk_q + 8'd1;
            if (last_blk) begin
              state_d = DONE;
            end else begin
              state_d = NEXT_CTR;
              ctr_d   = ctr_q + 32'd1;
            end
          end
        end
      end
      NEXT_CTR: begin
        bus.chacha_wr_ctr  = 1'b1;
        bus.chacha_data_in = ctr_shift[7:0];
        byte_d             = byte_q + 8'd1;
        if (byte_q == CTR_LAST) begin
          byte_d  = 8'd0;
          state_d = WAIT_BLK;
        end
      end
      DONE: begin
        if (!out_valid_q || bus.out_ready) begin
          bus.done = !rst;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_q      <= 8'd0;
      blk_q       <= 8'd0;
      nblk_q      <= 8'd0;
      ctr_q       <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      blk_q       <= blk_d;
      nblk_q      <= nblk_d;
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_chacha_driver.sv
// Randomized scoreboard bench for chacha_driver with a behavioural core model
// whose keystream byte is (read address XOR counter low byte).
module tb_chacha_driver;
  localparam int KB = 32;
  localparam int NB = 12;
  localparam int CB = 4;
  localparam int BB = 64;
  localparam int CFG_N = KB + NB + CB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chacha_driver_if bus();

  chacha_driver #(
    .KEY_BYTES(KB), .NNC_BYTES(NB), .CTR_BYTES(CB), .BLK_BYTES(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int exp_done = 0;
  int n_acc = 0;
  int blk_delay = 0;
  int ready_mode = 0;

  logic [10:0] exp_wr[$];   // {key,nnc,ctr strobe, data}
  logic [8:0]  exp_out[$];  // {last, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Core model
  logic [7:0] core_addr = 8'd0;
  logic [7:0] core_lsb = 8'd0;
  logic [1:0] core_cidx = 2'd0;
  logic       core_have = 1'b0;
  int         core_wait = 0;

  always @(posedge clk) begin
    if (rst) begin
      core_addr <= 8'd0;
      core_cidx <= 2'd0;
      core_have <= 1'b0;
      core_wait <= 0;
    end else begin
      if (bus.chacha_rd_blk) core_addr <= core_addr + 8'd1;
      if (core_wait > 0) core_wait <= core_wait - 1;
      if (bus.chacha_wr_ctr) begin
        core_cidx <= core_cidx + 2'd1;
        core_have <= 1'b0;
        if (core_cidx == 2'd0) core_lsb <= bus.chacha_data_in;
        if (core_cidx == 2'(CB - 1)) begin
          core_have <= 1'b1;
          core_addr <= 8'd0;
          core_wait <= blk_delay;
        end
      end
    end
  end

  assign bus.chacha_blk_ready = core_have && (core_wait == 0);
  assign bus.chacha_data_out  = core_addr ^ core_lsb;

  // Downstream ready driver
  initial begin
    logic [3:0] pat;
    int ph;
    pat = 4'b1001;
    ph = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin bus.out_ready = pat[ph % 4]; ph++; end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  always @(negedge clk) begin
    int ns;
    logic [10:0] w;
    logic [8:0] o;
    ns = int'(bus.chacha_wr_key) + int'(bus.chacha_wr_nnc) + int'(bus.chacha_wr_ctr);
    if (ns != 0) begin
      check("strobe_onehot", 32'(ns), 32'd1);
      if (bus.chacha_wr_key || bus.chacha_wr_nnc || bus.cfg_ready)
        check("strobe_needs_cfg_valid", 32'(bus.cfg_valid), 32'd1);
      check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_strobe", 32'({bus.chacha_wr_key, bus.chacha_wr_nnc, bus.chacha_wr_ctr}), 32'(w[10:8]));
        check("wr_data", 32'(bus.chacha_data_in), 32'(w[7:0]));
      end
    end
    if (bus.out_valid && !bus.out_ready)
      check("rd_blk_backpressure", 32'(bus.chacha_rd_blk), 32'd0);
    if (bus.chacha_rd_blk)
      check("rd_after_blk_ready", 32'(bus.chacha_blk_ready), 32'd1);
    if (bus.out_valid && bus.out_ready) begin
      n_acc++;
      check("out_expected", 32'(exp_out.size() != 0), 32'd1);
      if (exp_out.size() != 0) begin
        o = exp_out.pop_front();
        check("out_data", 32'(bus.out_data), 32'(o[7:0]));
        check("out_last", 32'(bus.out_last), 32'(o[8]));
      end
    end
    if (bus.done) begin
      check("done_expected", 32'(exp_done > 0), 32'd1);
      if (exp_done > 0) exp_done--;
    end
  end

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, 32'({bus.busy, bus.out_valid, bus.out_last, bus.cfg_ready, bus.done,
                                bus.chacha_wr_key, bus.chacha_wr_nnc, bus.chacha_wr_ctr,
                                bus.chacha_rd_blk}), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_data_in"}, 32'(bus.chacha_data_in), 32'd0);
  endtask

  task automatic session(input logic [7:0] cfg [CFG_N], input int n, input int gap,
                         input int dly, input int rmode, input int rst_at, input bit start_mid);
    logic [31:0] ctr0, cb, tmp;
    logic [7:0]  d;
    bit acc, did, start_hi;
    int t;
    blk_delay  = dly;
    ready_mode = rmode;
    n_acc      = 0;
    for (int i = 0; i < KB; i++) exp_wr.push_back({3'b100, cfg[i]});
    for (int i = KB; i < KB + NB; i++) exp_wr.push_back({3'b010, cfg[i]});
    for (int i = KB + NB; i < CFG_N; i++) exp_wr.push_back({3'b001, cfg[i]});
    ctr0 = {cfg[KB+NB+3], cfg[KB+NB+2], cfg[KB+NB+1], cfg[KB+NB]};
    for (int b = 0; b < n; b++) begin
      cb = ctr0 + 32'(b);
      if (b > 0)
        for (int j = 0; j < CB; j++) begin
          tmp = cb >> (8 * j);
          exp_wr.push_back({3'b001, tmp[7:0]});
        end
      for (int a = 0; a < BB; a++) begin
        d = 8'(a) ^ cb[7:0];
        exp_out.push_back({(b == n - 1) && (a == BB - 1), d});
      end
    end
    exp_done = exp_done + 1;

    bus.start = 1'b1;
    bus.num_blocks = 8'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;

    for (int i = 0; i < CFG_N; i++) begin
      if (gap > 0) begin
        bus.cfg_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = cfg[i];
      acc = 1'b0;
      t = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = bus.cfg_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!acc) begin
        check("cfg_accept", 32'(acc), 32'd1);
        break;
      end
    end
    bus.cfg_valid = 1'b0;

    did = 1'b0;
    start_hi = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      if (start_hi) begin bus.start = 1'b0; start_hi = 1'b0; end
      if (start_mid && !did && n_acc >= 5) begin
        bus.start = 1'b1;
        bus.num_blocks = 8'd7;
        start_hi = 1'b1;
        did = 1'b1;
      end
      if (rst_at > 0 && n_acc >= rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_wr.delete();
        exp_out.delete();
        exp_done = 0;
        @(negedge clk);
        check_idle("after_mid_reset");
        break;
      end
      if (exp_done == 0 && exp_out.size() == 0 && !start_hi) break;
    end
    bus.start = 1'b0;
    check("session_done_pulses", 32'(exp_done), 32'd0);
    check("session_out_drained", 32'(exp_out.size()), 32'd0);
    check("session_wr_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] cfg [CFG_N];
    bus.start = 1'b1;            // held through reset: reset must win
    bus.num_blocks = 8'd1;
    bus.cfg_valid = 1'b0;
    bus.cfg_data = 8'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Known bytes 0x00..0x2F, one block
    for (int i = 0; i < CFG_N; i++) cfg[i] = 8'(i);
    session(cfg, 1, 0, 0, 0, 0, 1'b0);

    // Backpressure 1,0,0,1 with zero counter (data = address), start during READ
    for (int i = 0; i < CFG_N; i++) cfg[i] = (i < KB + NB) ? 8'($urandom) : 8'd0;
    session(cfg, 1, 0, 0, 1, 0, 1'b1);

    // Counter wrap across two blocks
    for (int i = 0; i < CFG_N; i++) cfg[i] = (i < KB + NB) ? 8'($urandom) : 8'hFF;
    session(cfg, 2, 0, 0, 0, 0, 1'b0);

    // Config gaps, slow core, random backpressure
    for (int i = 0; i < CFG_N; i++) cfg[i] = 8'($urandom);
    session(cfg, 2, 3, 10, 2, 0, 1'b0);

    // Reset mid-READ, then a clean session
    for (int i = 0; i < CFG_N; i++) cfg[i] = 8'($urandom);
    session(cfg, 1, 0, 0, 0, 20, 1'b0);
    for (int i = 0; i < CFG_N; i++) cfg[i] = 8'($urandom);
    session(cfg, 3, 0, 2, 2, 0, 1'b0);

    // start with zero blocks is ignored
    ready_mode = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_blocks = 8'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("zero_blocks_busy", 32'(bus.busy), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/chacha_driver.md
CHACHA_DRIVER -- requirements
Module: chacha_driver

Interface
REQ-001 SHALL have parameter KEY_BYTES, default 32, key bytes written per session.
REQ-002 SHALL have parameter NNC_BYTES, default 12, nonce bytes written per session.
REQ-003 SHALL have parameter CTR_BYTES, default 4, counter bytes; the counter is little-endian.
REQ-004 SHALL have parameter BLK_BYTES, default 64, bytes read per block.
REQ-005 SHALL have the following ports, one per line:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  begin session; sampled in IDLE only.
  num_blocks  in  8  blocks per session; captured on start.
  cfg_valid  in  1  upstream config byte valid.
  cfg_data  in  8  key, then nonce, then counter bytes.
  cfg_ready  out  1  config byte accepted when valid&&ready.
  out_valid  out  1  keystream byte valid.
  out_data  out  8  keystream byte.
  out_last  out  1  final byte of final block.
  out_ready  in  1  downstream accept.
  busy  out  1  high whenever state != IDLE.
  done  out  1  one-cycle pulse at session end.
  chacha_wr_key  out  1  core key-write strobe.
  chacha_wr_nnc  out  1  core nonce-write strobe.
  chacha_wr_ctr  out  1  core counter-write strobe.
  chacha_data_in  out  8  core write byte.
  chacha_blk_ready  in  1  core block available.
  chacha_rd_blk  out  1  core read strobe; core advances its read address each cycle it is high.
  chacha_data_out  in  8  core byte at current read address, valid in the same cycle.

Function
REQ-006 SHALL implement states IDLE, LOAD_KEY, LOAD_NNC, LOAD_CTR, WAIT_BLK, READ, NEXT_CTR, DONE.
REQ-007 IDLE: start=1 with num_blocks!=0 SHALL go to LOAD_KEY; start with num_blocks=0 SHALL be ignored.
REQ-008 cfg_ready SHALL be high only in LOAD_KEY, LOAD_NNC and LOAD_CTR.
REQ-009 In a cycle with cfg_valid&&cfg_ready, the driver SHALL drive chacha_data_in=cfg_data combinationally with exactly one strobe matching the state; all strobes SHALL be low otherwise.
REQ-010 A byte counter SHALL advance per transfer, and the FSM SHALL move on after KEY_BYTES, NNC_BYTES and CTR_BYTES transfers respectively; cfg_valid gaps SHALL stall without error.
REQ-011 In LOAD_CTR, the driver SHALL also capture each byte into a 32-bit internal counter register (byte i into bits 8i+7:8i); after the last byte it SHALL go to WAIT_BLK.
REQ-012 WAIT_BLK SHALL last at least one full cycle and SHALL go to READ on the first cycle after entry in which chacha_blk_ready=1.
REQ-013 In READ, chacha_rd_blk SHALL equal (!out_valid || out_ready); out_data/out_valid SHALL load chacha_data_out/1 at the edge ending each rd_blk cycle.
REQ-014 out_valid SHALL stay high with out_data stable until out_ready; with out_ready held high, throughput SHALL be one byte per cycle.
REQ-015 After BLK_BYTES rd_blk cycles, the block counter SHALL increment; if it equals num_blocks, the FSM SHALL go to DONE, else to NEXT_CTR.
REQ-016 NEXT_CTR SHALL increment the internal counter modulo 2^32 (0xFFFFFFFF wraps to 0x00000000), write its CTR_BYTES LSB-first with chacha_wr_ctr over consecutive cycles, then go to WAIT_BLK.
REQ-017 out_last SHALL be high with the byte that is the final byte of the final block.
REQ-018 DONE SHALL wait until the last byte is accepted (out_valid=0 or out_valid&&out_ready), then pulse done for one cycle and return to IDLE.
REQ-019 start SHALL be ignored outside IDLE.

Reset
REQ-020 rst SHALL force state=IDLE; cfg_ready, out_valid, out_last, busy, done, all chacha strobes and chacha_rd_blk SHALL be 0; out_data, chacha_data_in and all counters SHALL be 0.
REQ-021 rst mid-session (any state) SHALL take effect at the next edge, discard the pending out byte, and not pulse done.
REQ-022 rst SHALL take priority over start in the same cycle.

Verification
REQ-023 Load, 1 block: start with num_blocks=1, 48 bytes 0x00..0x2F sent back-to-back -> 32 wr_key, 12 wr_nnc, 4 wr_ctr cycles; 64 bytes out; out_last on byte 64; done once.
REQ-024 Backpressure: out_ready toggled 1,0,0,1 -> rd_blk low whenever out_valid&&!out_ready; no byte lost or duplicated (model core returns address as data: 0..63).
REQ-025 Multi-block with wrap: counter bytes FF FF FF FF, num_blocks=2 -> NEXT_CTR writes 00 00 00 00; 128 bytes out; out_last only on byte 128.
REQ-026 Stalls: cfg_valid gaps of 3 cycles, chacha_blk_ready delayed 10 cycles -> no strobe during gaps; READ entered only after blk_ready.
REQ-027 Reset mid-READ at byte 20 -> next cycle IDLE, all outputs 0, no done; new start runs a clean session.
REQ-028 start with num_blocks=0 -> busy stays 0; start during READ -> ignored.
